// File: rtl/fwd_lookup_client_if.sv
// Bundle of the header, table-lookup, aging and forwarding-decision signals.
// master: the lookup client; slave: the ingress path, MAC table and egress logic around it.
interface fwd_lookup_client_if #(
  parameter int NUM_PORTS = 24
);
  logic                 hdr_valid;
  logic [4:0]           hdr_src_port;
  logic [11:0]          hdr_vlan;
  logic [47:0]          hdr_src_mac;
  logic [47:0]          hdr_dst_mac;

  logic                 lookup_en;
  logic [11:0]          lookup_src_vlan;
  logic [47:0]          lookup_src_mac;
  logic [4:0]           lookup_src_port;
  logic [47:0]          lookup_dst_mac;
  logic                 lookup_hit;
  logic [4:0]           lookup_dst_port;

  logic                 gc_en;
  logic                 gc_done;
  logic                 gc_force;
  logic                 gc_busy;

  logic                 fwd_valid;
  logic [NUM_PORTS-1:0] fwd_port_mask;
  logic                 fwd_flood;
  logic                 fwd_drop;

  modport master (
    input  hdr_valid, hdr_src_port, hdr_vlan, hdr_src_mac, hdr_dst_mac,
    output lookup_en, lookup_src_vlan, lookup_src_mac, lookup_src_port, lookup_dst_mac,
    input  lookup_hit, lookup_dst_port,
    output gc_en, gc_busy,
    input  gc_done, gc_force,
    output fwd_valid, fwd_port_mask, fwd_flood, fwd_drop
  );

  modport slave (
    output hdr_valid, hdr_src_port, hdr_vlan, hdr_src_mac, hdr_dst_mac,
    input  lookup_en, lookup_src_vlan, lookup_src_mac, lookup_src_port, lookup_dst_mac,
    output lookup_hit, lookup_dst_port,
    input  gc_en, gc_busy,
    output gc_done, gc_force,
    input  fwd_valid, fwd_port_mask, fwd_flood, fwd_drop
  );
endinterface

// File: rtl/fwd_lookup_client.sv
// MAC table lookup client: issues one lookup (with source learning) per header, tracks the
// table's fixed result latency, builds the forwarding port mask and schedules aging passes.
//
// GC FSM states:
//   state    | meaning
//   ST_COUNT | counting toward the next aging pass; gc_force starts one at once
//   ST_WAIT  | aging pass outstanding (gc_busy=1), waiting for gc_done
module fwd_lookup_client #(
  parameter int NUM_PORTS      = 24,
  parameter int LOOKUP_LATENCY = 3,
  parameter int GC_INTERVAL    = 156250000
) (
  input logic                 i_clk,
  input logic                 i_rst,
  fwd_lookup_client_if.master bus
);

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_WAIT  = 1'b1
  } gc_state_t;

  localparam logic [31:0] GC_TC = 32'(GC_INTERVAL - 1);
  localparam logic [5:0]  PORT_LIMIT = 6'(NUM_PORTS);

  // Request stage
  logic        r_lookup_en;
  logic [11:0] r_lookup_vlan;
  logic [47:0] r_lookup_src_mac;
  logic [4:0]  r_lookup_src_port;
  logic [47:0] r_lookup_dst_mac;
  logic        r_req_valid;
  logic        r_req_bypass;
  logic        r_req_dst_mc;
  logic        w_src_mc;

  assign w_src_mc = bus.hdr_src_mac[40];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lookup_en       <= 1'b0;
      r_lookup_vlan     <= '0;
      r_lookup_src_mac  <= '0;
      r_lookup_src_port <= '0;
      r_lookup_dst_mac  <= '0;
      r_req_valid       <= 1'b0;
      r_req_bypass      <= 1'b0;
      r_req_dst_mc      <= 1'b0;
    end else begin
      r_req_valid  <= bus.hdr_valid;
      r_lookup_en  <= bus.hdr_valid & ~w_src_mc;
      r_req_bypass <= bus.hdr_valid & w_src_mc;
      r_req_dst_mc <= bus.hdr_valid & bus.hdr_dst_mac[40];
      if (bus.hdr_valid) begin
        r_lookup_vlan     <= bus.hdr_vlan;
        r_lookup_src_mac  <= bus.hdr_src_mac;
        r_lookup_src_port <= bus.hdr_src_port;
        r_lookup_dst_mac  <= bus.hdr_dst_mac;
      end
    end
  end

  // Sideband rides alongside the table so the last stage lines up with lookup_hit.
  logic [LOOKUP_LATENCY-1:0]      r_sb_valid;
  logic [LOOKUP_LATENCY-1:0]      r_sb_bypass;
  logic [LOOKUP_LATENCY-1:0]      r_sb_dst_mc;
  logic [LOOKUP_LATENCY-1:0][4:0] r_sb_port;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sb_valid  <= '0;
      r_sb_bypass <= '0;
      r_sb_dst_mc <= '0;
      r_sb_port   <= '0;
    end else begin
      r_sb_valid[0]  <= r_req_valid;
      r_sb_bypass[0] <= r_req_bypass;
      r_sb_dst_mc[0] <= r_req_dst_mc;
      r_sb_port[0]   <= r_lookup_src_port;
      for (int i = 1; i < LOOKUP_LATENCY; i++) begin
        r_sb_valid[i]  <= r_sb_valid[i-1];
        r_sb_bypass[i] <= r_sb_bypass[i-1];
        r_sb_dst_mc[i] <= r_sb_dst_mc[i-1];
        r_sb_port[i]   <= r_sb_port[i-1];
      end
    end
  end

  // Decision
  logic                 w_d_valid;
  logic                 w_d_bypass;
  logic                 w_d_dst_mc;
  logic [4:0]           w_d_port;
  logic                 w_dst_oob;
  logic [NUM_PORTS-1:0] w_flood_mask;
  logic [NUM_PORTS-1:0] w_hit_mask;
  logic [NUM_PORTS-1:0] w_mask;
  logic                 w_flood;
  logic                 w_drop;

  assign w_d_valid  = r_sb_valid[LOOKUP_LATENCY-1];
  assign w_d_bypass = r_sb_bypass[LOOKUP_LATENCY-1];
  assign w_d_dst_mc = r_sb_dst_mc[LOOKUP_LATENCY-1];
  assign w_d_port   = r_sb_port[LOOKUP_LATENCY-1];
  assign w_dst_oob  = ({1'b0, bus.lookup_dst_port} >= PORT_LIMIT);

  // An out-of-range source port matches no bit, so flood then clears nothing.
  always_comb begin
    w_flood_mask = '1;
    w_hit_mask   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_d_port == 5'(i)) w_flood_mask[i] = 1'b0;
      if (bus.lookup_dst_port == 5'(i)) w_hit_mask[i] = 1'b1;
    end
  end

  always_comb begin
    w_mask  = '0;
    w_flood = 1'b0;
    w_drop  = 1'b0;
    if (w_d_bypass) begin
      w_drop = 1'b1;
    end else if (w_d_dst_mc || !bus.lookup_hit) begin
      w_mask  = w_flood_mask;
      w_flood = 1'b1;
    end else if (w_dst_oob || (bus.lookup_dst_port == w_d_port)) begin
      w_drop = 1'b1;
    end else begin
      w_mask = w_hit_mask;
    end
  end

  logic                 r_fwd_valid;
  logic [NUM_PORTS-1:0] r_fwd_mask;
  logic                 r_fwd_flood;
  logic                 r_fwd_drop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fwd_valid <= 1'b0;
      r_fwd_mask  <= '0;
      r_fwd_flood <= 1'b0;
      r_fwd_drop  <= 1'b0;
    end else begin
      r_fwd_valid <= w_d_valid;
      r_fwd_mask  <= w_d_valid ? w_mask : '0;
      r_fwd_flood <= w_d_valid & w_flood;
      r_fwd_drop  <= w_d_valid & w_drop;
    end
  end

  // Aging schedule
  gc_state_t   r_gc_state;
  gc_state_t   w_gc_state_next;
  logic [31:0] r_gc_cnt;
  logic [31:0] w_gc_cnt_next;
  logic        w_gc_en;
  logic        w_gc_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gc_state <= ST_COUNT;
      r_gc_cnt   <= '0;
    end else begin
      r_gc_state <= w_gc_state_next;
      r_gc_cnt   <= w_gc_cnt_next;
    end
  end

  // gc_en is a Mealy pulse so gc_force takes effect in the same cycle; masked during reset.
  always_comb begin
    w_gc_state_next = r_gc_state;
    w_gc_cnt_next   = r_gc_cnt;
    w_gc_en         = 1'b0;
    w_gc_busy       = 1'b0;
    case (r_gc_state)
      ST_COUNT: begin
        if ((r_gc_cnt == GC_TC) || bus.gc_force) begin
          w_gc_en         = ~i_rst;
          w_gc_state_next = ST_WAIT;
          w_gc_cnt_next   = '0;
        end else begin
          w_gc_cnt_next = r_gc_cnt + 32'd1;
        end
      end
      ST_WAIT: begin
        w_gc_busy = ~i_rst;
        if (bus.gc_done) begin
          w_gc_state_next = ST_COUNT;
          w_gc_cnt_next   = '0;
        end
      end
    endcase
  end

  assign bus.lookup_en       = r_lookup_en;
  assign bus.lookup_src_vlan = r_lookup_vlan;
  assign bus.lookup_src_mac  = r_lookup_src_mac;
  assign bus.lookup_src_port = r_lookup_src_port;
  assign bus.lookup_dst_mac  = r_lookup_dst_mac;
  assign bus.gc_en           = w_gc_en;
  assign bus.gc_busy         = w_gc_busy;
  assign bus.fwd_valid       = r_fwd_valid;
  assign bus.fwd_port_mask   = r_fwd_mask;
  assign bus.fwd_flood       = r_fwd_flood;
  assign bus.fwd_drop        = r_fwd_drop;

endmodule

// File: tb/tb_fwd_lookup_client.sv
// Bench for fwd_lookup_client: behavioural MAC table, expected-decision queue keyed by cycle,
// and an aging-schedule model, checked every cycle plus directed scenario checks.
module tb_fwd_lookup_client;
  localparam int NP  = 24;
  localparam int LAT = 3;
  localparam int GCI = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_lookup_client_if #(.NUM_PORTS(NP)) bus ();

  fwd_lookup_client #(
    .NUM_PORTS(NP), .LOOKUP_LATENCY(LAT), .GC_INTERVAL(GCI)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic [4:0] sp;
    logic       byp;
    logic       dmc;
  } hdr_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit          d_rst = 1'b1;
  bit          d_hv, d_force, d_done;
  logic [4:0]  d_sp;
  logic [11:0] d_vlan;
  logic [47:0] d_smac, d_dmac;

  bit          pv_en;
  logic [4:0]  pv_sp;
  logic [11:0] pv_vlan;
  logic [47:0] pv_smac, pv_dmac;

  hdr_t       exp_fwd[int];
  bit         rsp_h[int];
  logic [4:0] rsp_p[int];
  bit         log_h[int];
  logic [4:0] log_p[int];
  logic [4:0] tbl[logic [59:0]];

  bit gc_wait;
  int gc_elapsed;
  int gc_timer;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void decide(input hdr_t h, input bit hit, input logic [4:0] dp,
                                 output logic [NP-1:0] m, output bit fl, output bit dr);
    m  = '0;
    fl = 1'b0;
    dr = 1'b0;
    if (h.byp) dr = 1'b1;
    else if (h.dmc || !hit) begin
      fl = 1'b1;
      m  = '1;
      if (int'(h.sp) < NP) m[h.sp] = 1'b0;
    end else if (int'(dp) >= NP || dp == h.sp) dr = 1'b1;
    else m[dp] = 1'b1;
  endfunction

  task automatic hdr(input logic [4:0] sp, input logic [11:0] vl,
                     input logic [47:0] sm, input logic [47:0] dm);
    d_hv = 1'b1; d_sp = sp; d_vlan = vl; d_smac = sm; d_dmac = dm;
  endtask

  task automatic rnd_hdr();
    logic [47:0] sm, dm;
    sm = {40'h02_00_00_00_00, 8'($urandom_range(0, 5))};
    if ($urandom_range(0, 9) == 0) sm[40] = 1'b1;
    dm = {40'h02_00_00_00_00, 8'($urandom_range(0, 7))};
    if ($urandom_range(0, 6) == 0) dm = 48'hFFFF_FFFF_FFFF;
    hdr(5'($urandom_range(0, 27)), 12'($urandom_range(1, 2)), sm, dm);
  endtask

  task automatic step();
    bit done_now, eg, ev, ef, ed;
    logic [NP-1:0] em;
    hdr_t h;
    @(negedge clk);
    cyc++;
    done_now = d_done;
    if (gc_timer > 0) begin
      gc_timer--;
      if (gc_timer == 0) done_now = 1'b1;
    end
    rst              = d_rst;
    bus.hdr_valid    = d_hv;
    bus.hdr_src_port = d_sp;
    bus.hdr_vlan     = d_vlan;
    bus.hdr_src_mac  = d_smac;
    bus.hdr_dst_mac  = d_dmac;
    bus.gc_force     = d_force;
    bus.gc_done      = done_now;
    if (rsp_h.exists(cyc)) begin
      bus.lookup_hit      = rsp_h[cyc];
      bus.lookup_dst_port = rsp_p[cyc];
    end else begin
      bus.lookup_hit      = 1'($urandom);
      bus.lookup_dst_port = 5'($urandom);
    end
    log_h[cyc] = bus.lookup_hit;
    log_p[cyc] = bus.lookup_dst_port;
    #1;

    chk("lookup_en", bus.lookup_en, pv_en);
    if (pv_en) begin
      chk("lookup_vlan", bus.lookup_src_vlan, pv_vlan);
      chk("lookup_src_mac", bus.lookup_src_mac, pv_smac);
      chk("lookup_src_port", bus.lookup_src_port, pv_sp);
      chk("lookup_dst_mac", bus.lookup_dst_mac, pv_dmac);
    end
    if (exp_fwd.exists(cyc)) begin
      ev = 1'b1;
      decide(exp_fwd[cyc], log_h[cyc-1], log_p[cyc-1], em, ef, ed);
      exp_fwd.delete(cyc);
    end else begin
      ev = 1'b0; em = '0; ef = 1'b0; ed = 1'b0;
    end
    chk("fwd_valid", bus.fwd_valid, ev);
    chk("fwd_port_mask", bus.fwd_port_mask, em);
    chk("fwd_flood", bus.fwd_flood, ef);
    chk("fwd_drop", bus.fwd_drop, ed);
    eg = !d_rst && !gc_wait && (gc_elapsed == GCI - 1 || d_force);
    chk("gc_en", bus.gc_en, eg);
    chk("gc_busy", bus.gc_busy, !d_rst && gc_wait);

    // The table samples a request at the end of this cycle: look up dst, then learn src.
    if (pv_en) begin
      rsp_h[cyc+LAT] = tbl.exists({pv_vlan, pv_dmac});
      rsp_p[cyc+LAT] = rsp_h[cyc+LAT] ? tbl[{pv_vlan, pv_dmac}] : 5'($urandom);
      tbl[{pv_vlan, pv_smac}] = pv_sp;
    end

    if (d_rst) begin
      exp_fwd.delete();
      pv_en = 1'b0; gc_wait = 1'b0; gc_elapsed = 0; gc_timer = 0;
    end else begin
      pv_en = d_hv && !d_smac[40];
      if (d_hv) begin
        pv_sp = d_sp; pv_vlan = d_vlan; pv_smac = d_smac; pv_dmac = d_dmac;
        h.sp = d_sp; h.byp = d_smac[40]; h.dmc = d_dmac[40];
        exp_fwd[cyc+2+LAT] = h;
      end
      if (eg) begin
        gc_wait = 1'b1; gc_elapsed = 0; gc_timer = 40;
      end else if (gc_wait && done_now) begin
        gc_wait = 1'b0; gc_elapsed = 0;
      end else if (!gc_wait) begin
        gc_elapsed++;
      end
    end
    d_hv = 1'b0; d_force = 1'b0; d_done = 1'b0;
  endtask

  initial begin
    int first, second, third, seen, cd;
    bus.hdr_valid = 1'b0; bus.hdr_src_port = '0; bus.hdr_vlan = '0;
    bus.hdr_src_mac = '0; bus.hdr_dst_mac = '0;
    bus.lookup_hit = 1'b0; bus.lookup_dst_port = '0;
    bus.gc_done = 1'b0; bus.gc_force = 1'b0;
    d_sp = '0; d_vlan = '0; d_smac = '0; d_dmac = '0;

    d_rst = 1'b1;
    repeat (3) step();
    d_rst = 1'b0;
    repeat (8) step();

    // Empty table: miss floods everything except the ingress port.
    hdr(5'd12, 12'd2, 48'h02de_adbe_ef0c, 48'h02de_adbe_ef0a);
    step();
    step();
    chk("p1_lookup_en", bus.lookup_en, 1'b1);
    repeat (LAT + 1) step();
    chk("p1_fwd_valid", bus.fwd_valid, 1'b1);
    chk("p1_mask", bus.fwd_port_mask, 24'hFF_EFFF);
    chk("p1_flood", bus.fwd_flood, 1'b1);

    // Learned destination, then the hairpin case.
    hdr(5'd10, 12'd2, 48'h02de_adbe_ef0b, 48'h02de_adbe_ef0c);
    step();
    repeat (LAT + 2) step();
    chk("p2_unicast_mask", bus.fwd_port_mask, 24'h00_1000);
    chk("p2_unicast_flood", bus.fwd_flood, 1'b0);
    hdr(5'd12, 12'd2, 48'h02de_adbe_ef0b, 48'h02de_adbe_ef0c);
    step();
    repeat (LAT + 2) step();
    chk("p2_hairpin_drop", bus.fwd_drop, 1'b1);
    chk("p2_hairpin_mask", bus.fwd_port_mask, 24'h0);

    // Broadcast destination, then a multicast source bypass.
    hdr(5'd0, 12'd2, 48'h02de_adbe_ef01, 48'hFFFF_FFFF_FFFF);
    step();
    repeat (LAT + 2) step();
    chk("p3_bcast_mask", bus.fwd_port_mask, 24'hFF_FFFE);
    chk("p3_bcast_flood", bus.fwd_flood, 1'b1);
    hdr(5'd5, 12'd2, 48'h0300_0000_0001, 48'h02de_adbe_ef0c);
    step();
    step();
    chk("p3_bypass_no_lookup", bus.lookup_en, 1'b0);
    repeat (LAT + 1) step();
    chk("p3_bypass_valid", bus.fwd_valid, 1'b1);
    chk("p3_bypass_drop", bus.fwd_drop, 1'b1);

    // Back-to-back burst.
    for (int i = 0; i < 8; i++) begin
      rnd_hdr();
      step();
    end
    repeat (LAT + 3) step();

    // Reset in the middle of a burst: nothing in flight may emerge.
    for (int i = 0; i < 6; i++) begin
      rnd_hdr();
      if (i == 5) d_rst = 1'b1;
      step();
    end
    d_rst = 1'b0;
    first = -1;
    seen  = 0;
    for (int i = 0; i < 200 && first < 0; i++) begin
      step();
      if (i == 0) chk("p4_rst_lookup_en", bus.lookup_en, 1'b0);
      if (i < LAT + 4 && bus.fwd_valid === 1'b1) seen++;
      if (bus.gc_en === 1'b1) first = i;
    end
    chk("p4_no_fwd_after_rst", 64'(seen), 64'd0);
    chk("p5_first_gc_en", 64'(first), 64'd99);

    second = -1;
    for (int i = 1; i < 300 && second < 0; i++) begin
      step();
      if (i == 20) chk("p5_busy_in_wait", bus.gc_busy, 1'b1);
      if (bus.gc_en === 1'b1) second = i;
    end
    chk("p5_gc_period", 64'(second), 64'd140);

    // Force while waiting is ignored; spurious done while counting is ignored.
    repeat (10) step();
    d_force = 1'b1;
    step();
    chk("p6_force_in_wait", bus.gc_en, 1'b0);
    cd = -1;
    for (int i = 0; i < 100 && cd < 0; i++) begin
      step();
      if (!gc_wait) cd = cyc;
    end
    repeat (20) step();
    d_done = 1'b1;
    step();
    chk("p6_count_busy", bus.gc_busy, 1'b0);
    third = -1;
    for (int i = 0; i < 200 && third < 0; i++) begin
      step();
      if (bus.gc_en === 1'b1) third = cyc;
    end
    chk("p6_spurious_done", 64'(third - cd), 64'd100);

    cd = -1;
    for (int i = 0; i < 100 && cd < 0; i++) begin
      step();
      if (!gc_wait) cd = cyc;
    end
    repeat (10) step();
    d_force = 1'b1;
    step();
    chk("p6_force_in_count", bus.gc_en, 1'b1);

    // Random traffic with occasional forced passes and stray done strobes.
    repeat (600) begin
      if ($urandom_range(0, 9) < 7) rnd_hdr();
      if ($urandom_range(0, 49) == 0) d_force = 1'b1;
      if ($urandom_range(0, 49) == 0) d_done = 1'b1;
      step();
    end
    repeat (LAT + 4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
